// File: rtl/mdu_if.sv
// Command/result bundle between the EX-stage operand muxes and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [3:0]  MDUop;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    modport master (
        output start, MDUop, in_1, in_2,
        input  busy, HI, LO, MDUout
    );

    modport slave (
        input  start, MDUop, in_1, in_2,
        output busy, HI, LO, MDUout
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed at accept and
// committed after a fixed busy window so the pipeline sees a deterministic latency.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    mdu_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               wr_q,     wr_d;
    logic [31:0]        hi_q,     hi_d;
    logic [31:0]        lo_q,     lo_d;

    logic               accept;
    logic               is_signed_mul;
    logic [63:0]        mul_a;
    logic [63:0]        mul_b;
    logic [63:0]        product;

    logic               neg_a;
    logic               neg_b;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        divisor_safe;
    logic [31:0]        uquot;
    logic [31:0]        urem;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign accept = bus.start && (state_q == S_IDLE);

    // Sign-extend for mult, zero-extend for multu; low 64 bits are correct either way.
    always_comb begin
        is_signed_mul = (bus.MDUop == OP_MULT);
        mul_a   = {is_signed_mul ? {32{bus.in_1[31]}} : 32'h0, bus.in_1};
        mul_b   = {is_signed_mul ? {32{bus.in_2[31]}} : 32'h0, bus.in_2};
        product = mul_a * mul_b;
    end

    // Signed division via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    always_comb begin
        neg_a        = (bus.MDUop == OP_DIV) && bus.in_1[31];
        neg_b        = (bus.MDUop == OP_DIV) && bus.in_2[31];
        abs_a        = neg_a ? (32'h0 - bus.in_1) : bus.in_1;
        abs_b        = neg_b ? (32'h0 - bus.in_2) : bus.in_2;
        divisor_safe = (abs_b == 32'h0) ? 32'h1 : abs_b;
        uquot        = abs_a / divisor_safe;
        urem         = abs_a % divisor_safe;
        quot         = (neg_a ^ neg_b) ? (32'h0 - uquot) : uquot;
        rem          = neg_a ? (32'h0 - urem) : urem;
    end

    // Next-state and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (bus.MDUop)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(MULT_CYCLES - 1);
                            res_hi_d = product[63:32];
                            res_lo_d = product[31:0];
                            wr_d     = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            res_hi_d = rem;
                            res_lo_d = quot;
                            wr_d     = (bus.in_2 != 32'h0);
                        end
                        OP_MTHI: hi_d = bus.in_1;
                        OP_MTLO: lo_d = bus.in_1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = S_IDLE;
                    wr_d    = 1'b0;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // Read port is combinational so mfhi/mflo resolve in the same EX cycle.
    assign bus.MDUout = (bus.MDUop == OP_MFHI) ? hi_q :
                        (bus.MDUop == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: move-to/from, mult/div results, busy window,
// ignored commands while busy, operand latching and asynchronous reset mid-operation.
module tb_mdu_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mdu_if bus ();

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command, scramble operands after accept, then check the busy window length.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n);
        bus.start = 1'b1;
        bus.MDUop = op;
        bus.in_1  = a;
        bus.in_2  = b;
        step();
        bus.start = 1'b0;
        bus.MDUop = 4'd0;
        bus.in_1  = 32'hDEAD_BEEF;
        bus.in_2  = 32'h0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
            step();
        end
        chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.MDUop = 4'd0;
        bus.in_1  = 32'h0;
        bus.in_2  = 32'h0;
        repeat (3) step();
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        step();

        // mthi / mtlo and combinational reads
        bus.start = 1'b1; bus.MDUop = 4'd5; bus.in_1 = 32'h1234_5678;
        step();
        chk("mthi_hi", bus.HI, 32'h1234_5678);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        bus.MDUop = 4'd6; bus.in_1 = 32'h9ABC_DEF0;
        step();
        chk("mtlo_lo", bus.LO, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", bus.HI, 32'h1234_5678);
        bus.start = 1'b0; bus.MDUop = 4'd7;
        #1 chk("mfhi", bus.MDUout, 32'h1234_5678);
        bus.MDUop = 4'd8;
        #1 chk("mflo", bus.MDUout, 32'h9ABC_DEF0);
        bus.MDUop = 4'd0;
        #1 chk("mdu_none", bus.MDUout, 32'h0);
        bus.MDUop = 4'd15;
        #1 chk("mdu_bad_op", bus.MDUout, 32'h0);
        step();

        // multiply
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
        chk("multu_hi", bus.HI, 32'h0000_0001);
        chk("multu_lo", bus.LO, 32'hFFFF_FFFE);
        run_op("mult_nn", 4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5);
        chk("mult_nn_hi", bus.HI, 32'h0);
        chk("mult_nn_lo", bus.LO, 32'd15);

        // divide
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10);
        chk("divu_lo", bus.LO, 32'd3);
        chk("divu_hi", bus.HI, 32'd1);
        run_op("div_pn", 4'd3, 32'd7, 32'hFFFF_FFFE, 10);
        chk("div_pn_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_pn_hi", bus.HI, 32'd1);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("div_ovf_lo", bus.LO, 32'h8000_0000);
        chk("div_ovf_hi", bus.HI, 32'h0);
        run_op("divu_big", 4'd4, 32'hFFFF_FFFF, 32'h0001_0000, 10);
        chk("divu_big_lo", bus.LO, 32'h0000_FFFF);
        chk("divu_big_hi", bus.HI, 32'h0000_FFFF);

        // divide by zero leaves HI/LO alone
        bus.start = 1'b1; bus.MDUop = 4'd5; bus.in_1 = 32'hAAAA_0000;
        step();
        bus.MDUop = 4'd6; bus.in_1 = 32'h0000_BBBB;
        step();
        run_op("div0", 4'd3, 32'd5, 32'd0, 10);
        chk("div0_hi", bus.HI, 32'hAAAA_0000);
        chk("div0_lo", bus.LO, 32'h0000_BBBB);

        // mtlo while busy is dropped; mflo during busy returns the old LO
        bus.start = 1'b1; bus.MDUop = 4'd1; bus.in_1 = 32'd3; bus.in_2 = 32'd4;
        step();
        bus.start = 1'b0; bus.MDUop = 4'd8; bus.in_1 = 32'h7777_7777; bus.in_2 = 32'h9;
        #1 chk("mflo_busy", bus.MDUout, 32'h0000_BBBB);
        step();
        bus.start = 1'b1; bus.MDUop = 4'd6; bus.in_1 = 32'h55;
        step();
        chk("ign_lo", bus.LO, 32'h0000_BBBB);
        bus.start = 1'b0; bus.MDUop = 4'd0;
        step();
        step();
        chk("ign_busy_last", 32'(bus.busy), 32'd1);
        step();
        chk("ign_busy_done", 32'(bus.busy), 32'd0);
        chk("ign_mult_hi", bus.HI, 32'h0);
        chk("ign_mult_lo", bus.LO, 32'd12);
        step();
        chk("ign_not_queued", bus.LO, 32'd12);

        // asynchronous reset in the third busy cycle of a div
        bus.start = 1'b1; bus.MDUop = 4'd4; bus.in_1 = 32'd100; bus.in_2 = 32'd7;
        step();
        bus.start = 1'b0; bus.MDUop = 4'd0;
        step();
        step();
        chk("rst_mid_busy_pre", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_hi", bus.HI, 32'h0);
        chk("rst_mid_lo", bus.LO, 32'h0);
        step();
        reset_n = 1'b1;
        repeat (10) step();
        chk("rst_no_wr_hi", bus.HI, 32'h0);
        chk("rst_no_wr_lo", bus.LO, 32'h0);
        chk("rst_no_wr_busy", 32'(bus.busy), 32'd0);

        // commands resume normally after reset
        bus.start = 1'b1; bus.MDUop = 4'd5; bus.in_1 = 32'h0000_CAFE;
        step();
        bus.start = 1'b0; bus.MDUop = 4'd7;
        #1 chk("post_rst_mfhi", bus.MDUout, 32'h0000_CAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Fed from the same operand bypass muxes (in_1 = rs value, in_2 = rt value).
- Owns the HI/LO architectural registers.
- Serves mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Exposes busy so the hazard unit can stall the decode stage.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  command qualifier; MDUop is sampled only when start=1.
- MDUop  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 mfhi, 1000 mflo; other codes = none.
- in_1  input  32  rs operand (dividend, multiplicand, mthi/mtlo source).
- in_2  input  32  rt operand (divisor, multiplier).
- busy  output  1  1 while a mult/div is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUout  output  32  combinational: HI when MDUop=mfhi, LO when MDUop=mflo, else 0.

Behaviour:
- Reset (reset_n=0, async, any time including mid-operation):
  - HI=0, LO=0, busy=0, cycle counter=0, pending results cleared.
  - The first edge after release accepts commands normally.
- Accept rule:
  - A command is accepted on a rising edge when start=1 and busy=0.
  - start while busy=1 is ignored; nothing is queued. The hazard unit must stall the issuing instruction.
- mult/multu accepted at edge T:
  - The 64-bit product is captured internally at T; signed for mult, unsigned for multu.
  - busy=1 from after T until edge T+MULT_CYCLES.
  - At edge T+MULT_CYCLES: HI=product[63:32], LO=product[31:0], busy=0.
  - A new command is accepted at the first edge where busy=0 is seen, i.e. T+MULT_CYCLES+1 earliest.
- div/divu:
  - Same timing as mult/multu, using DIV_CYCLES.
  - Result: LO=quotient, HI=remainder.
  - div is signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the full busy window still runs; HI/LO stay unchanged at completion.
- mthi/mtlo:
  - Single-cycle: HI (or LO)=in_1 at the accepting edge.
  - busy stays 0; the other register is untouched.
- mfhi/mflo:
  - Pure combinational read; start is irrelevant.
  - While busy=1, MDUout returns the old value. Stalling the read is the hazard unit's job.
- HI/LO update only at a mult/div completion edge, a mthi/mtlo accept edge, or reset.
- Internal states: IDLE (busy=0) -> RUN (counter counts down from N-1 to 0) -> IDLE at the completion edge.
- Operands are latched at accept; changes to in_1/in_2 during RUN have no effect.

Test Plan:
- Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 -> HI/LO show those values the cycle after; busy stays 0; mfhi gives MDUout=0x12345678.
- mult in_1=0xFFFFFFFF, in_2=2 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div in_1=-7 (0xFFFFFFF9), in_2=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- div by 0 with HI=0xAAAA0000, LO=0x0000BBBB -> busy for 10 cycles; HI/LO unchanged afterwards.
- Pulse start+mtlo 0x55 while busy during a mult -> ignored; LO equals the mult result; operand changes during RUN do not alter the result.
- Assert reset_n=0 in the 3rd busy cycle of a div -> busy, HI and LO drop to 0 immediately; no write occurs when the would-be completion edge arrives.
